// File: rtl/alu_seq_if.sv
// Operation-select type and the issue/result handshake bundle for alu_seq.
// Issue side: an op moves when in_valid & in_ready; result side: it moves when out_valid & out_ready.
package alu_types_pkg;
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLT  = 4'd5,
        ALU_SLTU = 4'd6,
        ALU_SLL  = 4'd7,
        ALU_SRL  = 4'd8,
        ALU_SRA  = 4'd9
    } alu_control_t;
endpackage

interface alu_seq_if #(
    parameter int N = 32
);
    logic                        in_valid;
    logic                        in_ready;
    logic [N-1:0]                a;
    logic [N-1:0]                b;
    alu_types_pkg::alu_control_t control;
    logic                        out_valid;
    logic                        out_ready;
    logic [N-1:0]                result;
    logic                        overflow;
    logic                        zero;
    logic                        equal;
    logic                        busy;
    logic [1:0]                  dbg_state;

    modport master (
        output in_valid, a, b, control, out_ready,
        input  in_ready, out_valid, result, overflow, zero, equal, busy, dbg_state
    );

    modport slave (
        input  in_valid, a, b, control, out_ready,
        output in_ready, out_valid, result, overflow, zero, equal, busy, dbg_state
    );
endinterface

// File: rtl/alu_seq.sv
// Multi-cycle handshaked N-bit ALU; shifts iterate one bit per cycle unless
// ALU_SEQ_BARREL_SHIFT_EN is defined, which selects a single-cycle barrel shifter.
module alu_seq
    import alu_types_pkg::*;
#(
    parameter int N = 32
) (
    input  logic     clk,
    input  logic     rst,
    alu_seq_if.slave bus
);
    localparam int SHIFT_W = $clog2(N);

`ifdef ALU_SEQ_BARREL_SHIFT_EN
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;
`endif

    state_t       state_q, state_d;
    logic [N-1:0] a_q, a_d;
    logic [N-1:0] b_q, b_d;
    alu_control_t ctrl_q, ctrl_d;
    logic [N-1:0] res_q, res_d;
    logic         ovf_q, ovf_d;
    logic         zero_q, zero_d;
    logic         eq_q, eq_d;

    logic               in_ready;
    logic               accept;
    logic [N-1:0]       sum;
    logic [N-1:0]       diff;
    logic [N-1:0]       alu_res;
    logic               alu_ovf;
    logic [SHIFT_W-1:0] shamt;

`ifndef ALU_SEQ_BARREL_SHIFT_EN
    logic [N-1:0]       work_q, work_d;
    logic [SHIFT_W-1:0] cnt_q, cnt_d;
    logic [N-1:0]       step;
    logic               is_shift;
`endif

    assign in_ready = (state_q == IDLE) || ((state_q == DONE) && bus.out_ready);
    assign accept   = bus.in_valid && in_ready;
    assign shamt    = b_q[SHIFT_W-1:0];

    always_comb begin : alu_core
        sum     = a_q + b_q;
        diff    = a_q - b_q;
        alu_res = '0;
        alu_ovf = 1'b0;
`ifndef ALU_SEQ_BARREL_SHIFT_EN
        is_shift = 1'b0;
`endif
        case (ctrl_q)
            ALU_ADD: begin
                alu_res = sum;
                alu_ovf = (a_q[N-1] == b_q[N-1]) && (sum[N-1] != a_q[N-1]);
            end
            ALU_SUB: begin
                alu_res = diff;
                alu_ovf = (a_q[N-1] != b_q[N-1]) && (diff[N-1] != a_q[N-1]);
            end
            ALU_AND:  alu_res = a_q & b_q;
            ALU_OR:   alu_res = a_q | b_q;
            ALU_XOR:  alu_res = a_q ^ b_q;
            ALU_SLT:  alu_res = {{(N-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
            ALU_SLTU: alu_res = {{(N-1){1'b0}}, (a_q < b_q)};
`ifdef ALU_SEQ_BARREL_SHIFT_EN
            ALU_SLL:  alu_res = a_q << shamt;
            ALU_SRL:  alu_res = a_q >> shamt;
            ALU_SRA:  alu_res = $unsigned($signed(a_q) >>> shamt);
`else
            // Only the zero-amount case finishes in EXEC; it returns a unchanged.
            ALU_SLL, ALU_SRL, ALU_SRA: begin
                is_shift = 1'b1;
                alu_res  = a_q;
            end
`endif
            default: alu_res = '0;
        endcase
    end

`ifndef ALU_SEQ_BARREL_SHIFT_EN
    always_comb begin : shift_step
        step = work_q;
        case (ctrl_q)
            ALU_SLL: step = {work_q[N-2:0], 1'b0};
            ALU_SRL: step = {1'b0, work_q[N-1:1]};
            ALU_SRA: step = {work_q[N-1], work_q[N-1:1]};
            default: step = work_q;
        endcase
    end
`endif

    always_comb begin : fsm_next
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        ctrl_d  = ctrl_q;
        res_d   = res_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        eq_d    = eq_q;
`ifndef ALU_SEQ_BARREL_SHIFT_EN
        work_d  = work_q;
        cnt_d   = cnt_q;
`endif
        case (state_q)
            IDLE: state_d = IDLE;
            EXEC: begin
`ifndef ALU_SEQ_BARREL_SHIFT_EN
                if (is_shift && (shamt != '0)) begin
                    work_d  = a_q;
                    cnt_d   = shamt;
                    state_d = SHIFT;
                end else
`endif
                begin
                    res_d   = alu_res;
                    ovf_d   = alu_ovf;
                    zero_d  = (alu_res == '0);
                    eq_d    = (a_q == b_q);
                    state_d = DONE;
                end
            end
`ifndef ALU_SEQ_BARREL_SHIFT_EN
            SHIFT: begin
                work_d = step;
                cnt_d  = cnt_q - SHIFT_W'(1);
                if (cnt_q == SHIFT_W'(1)) begin
                    res_d   = step;
                    ovf_d   = 1'b0;
                    zero_d  = (step == '0);
                    eq_d    = (a_q == b_q);
                    state_d = DONE;
                end
            end
`endif
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A new op can only be taken from IDLE or from DONE while the result leaves.
        if (accept) begin
            a_d     = bus.a;
            b_d     = bus.b;
            ctrl_d  = bus.control;
            state_d = EXEC;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            ctrl_q  <= ALU_ADD;
            res_q   <= '0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
            eq_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            ctrl_q  <= ctrl_d;
            res_q   <= res_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
            eq_q    <= eq_d;
        end
    end

`ifndef ALU_SEQ_BARREL_SHIFT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            work_q <= '0;
            cnt_q  <= '0;
        end else begin
            work_q <= work_d;
            cnt_q  <= cnt_d;
        end
    end
`endif

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.result    = res_q;
    assign bus.overflow  = ovf_q;
    assign bus.zero      = zero_q;
    assign bus.equal     = eq_q;
    assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed scenarios plus an ordered random stream.
module tb_alu_seq;
    import alu_types_pkg::*;

    localparam int N = 32;
    localparam int W = N + 3;

`ifdef ALU_SEQ_BARREL_SHIFT_EN
    localparam int SHIFT_EXTRA = 0;
`else
    localparam int SHIFT_EXTRA = 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    logic [W-1:0] exp_q[$];

    alu_seq_if #(.N(N)) bus ();

    alu_seq #(.N(N)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference: overflow from a sign-extended N+1-bit sum, shifts by operator.
    function automatic logic [W-1:0] model(input alu_control_t op, input logic [N-1:0] a,
                                            input logic [N-1:0] b);
        logic [N:0]   w;
        logic [N-1:0] r;
        logic         v;
        int           sh;
        r  = '0;
        v  = 1'b0;
        sh = int'(b % N);
        case (op)
            ALU_ADD:  begin w = {a[N-1], a} + {b[N-1], b}; r = w[N-1:0]; v = w[N] ^ w[N-1]; end
            ALU_SUB:  begin w = {a[N-1], a} - {b[N-1], b}; r = w[N-1:0]; v = w[N] ^ w[N-1]; end
            ALU_AND:  r = a & b;
            ALU_OR:   r = a | b;
            ALU_XOR:  r = a ^ b;
            ALU_SLT:  r = {{(N-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU: r = {{(N-1){1'b0}}, (a < b)};
            ALU_SLL:  r = a << sh;
            ALU_SRL:  r = a >> sh;
            ALU_SRA:  r = $unsigned($signed(a) >>> sh);
            default:  r = '0;
        endcase
        return {v, (r == '0), (a == b), r};
    endfunction

    task automatic drive_idle();
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.control   = ALU_ADD;
        bus.out_ready = 1'b0;
    endtask

    // Called one time unit after a rising edge; returns one unit after the accept edge.
    task automatic send(input alu_control_t op, input logic [N-1:0] a, input logic [N-1:0] b,
                        output bit ok);
        int n;
        n = 0;
        bus.control  = op;
        bus.a        = a;
        bus.b        = b;
        bus.in_valid = 1'b1;
        #1;
        while (!bus.in_ready && n < 200) begin
            @(posedge clk);
            #2;
            n++;
        end
        ok = bus.in_ready;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic take();
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        bit ok;
        int lat;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({bus.out_valid, bus.busy, bus.overflow, bus.zero, bus.equal, bus.result} !== '0) begin
            failures++;
            $display("FAIL reset_state: got ov=%b busy=%b flags=%b%b%b result=%h required all zero",
                     bus.out_valid, bus.busy, bus.overflow, bus.zero, bus.equal, bus.result);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready: got %b required 1", bus.in_ready);
        end
        @(posedge clk);
        #1;
        send(ALU_ADD, 32'd5, 32'd6, ok);
        wait_out(lat);
        checks++;
        if (!ok || bus.result !== 32'd11) begin
            failures++;
            $display("FAIL reset_pre_add: got accept=%0d result=%h required accept=1 result=0000000b", ok, bus.result);
        end
        take();
        send(ALU_SLL, 32'd1, 32'd20, ok);
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (bus.busy !== 1'b1 || bus.out_valid !== (SHIFT_EXTRA == 0)) begin
            failures++;
            $display("FAIL reset_mid_op: got busy=%b out_valid=%b required busy=1 out_valid=%b",
                     bus.busy, bus.out_valid, (SHIFT_EXTRA == 0));
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.out_valid, bus.busy, bus.result, bus.dbg_state} !== '0) begin
            failures++;
            $display("FAIL reset_async: got out_valid=%b busy=%b result=%h state=%0d required all zero",
                     bus.out_valid, bus.busy, bus.result, bus.dbg_state);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_ready: got %b required 1", bus.in_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_add_overflow();
        bit ok;
        int lat;
        send(ALU_ADD, 32'h7FFF_FFFF, 32'h0000_0001, ok);
        wait_out(lat);
        checks++;
        if (!ok || lat != 1) begin
            failures++;
            $display("FAIL add_latency: got accept=%0d lat=%0d required accept=1 lat=1", ok, lat);
        end
        checks++;
        if ({bus.overflow, bus.zero, bus.equal, bus.result} !== {3'b100, 32'h8000_0000}) begin
            failures++;
            $display("FAIL add_ovf: got ovf=%b z=%b eq=%b res=%h required ovf=1 z=0 eq=0 res=80000000",
                     bus.overflow, bus.zero, bus.equal, bus.result);
        end
        take();
    endtask

    task automatic test_sub_slt();
        bit ok;
        int lat;
        send(ALU_SUB, 32'h0000_BEEF, 32'h0000_BEEF, ok);
        wait_out(lat);
        checks++;
        if ({bus.overflow, bus.zero, bus.equal, bus.result} !== {3'b011, 32'h0}) begin
            failures++;
            $display("FAIL sub_equal: got ovf=%b z=%b eq=%b res=%h required ovf=0 z=1 eq=1 res=0",
                     bus.overflow, bus.zero, bus.equal, bus.result);
        end
        take();
        send(ALU_SLT, 32'hFFFF_FFFF, 32'h0000_0001, ok);
        wait_out(lat);
        checks++;
        if ({bus.overflow, bus.zero, bus.result} !== {2'b00, 32'h1}) begin
            failures++;
            $display("FAIL slt_signed: got ovf=%b z=%b res=%h required ovf=0 z=0 res=00000001",
                     bus.overflow, bus.zero, bus.result);
        end
        take();
        send(ALU_SLTU, 32'hFFFF_FFFF, 32'h0000_0001, ok);
        wait_out(lat);
        checks++;
        if ({bus.zero, bus.result} !== {1'b1, 32'h0}) begin
            failures++;
            $display("FAIL sltu_unsigned: got z=%b res=%h required z=1 res=0", bus.zero, bus.result);
        end
        take();
    endtask

    task automatic test_shift();
        bit ok;
        int lat;
        send(ALU_SRA, 32'h8000_0000, 32'd4, ok);
        wait_out(lat);
        checks++;
        if (lat != 1 + 4 * SHIFT_EXTRA || bus.result !== 32'hF800_0000) begin
            failures++;
            $display("FAIL sra_4: got lat=%0d res=%h required lat=%0d res=f8000000",
                     lat, bus.result, 1 + 4 * SHIFT_EXTRA);
        end
        take();
        send(ALU_SLL, 32'hA5A5_0F0F, 32'd0, ok);
        wait_out(lat);
        checks++;
        if (lat != 1 || bus.result !== 32'hA5A5_0F0F) begin
            failures++;
            $display("FAIL sll_0: got lat=%0d res=%h required lat=1 res=a5a50f0f", lat, bus.result);
        end
        take();
        send(ALU_SRL, 32'h8000_0000, 32'd31, ok);
        wait_out(lat);
        checks++;
        if (lat != 1 + 31 * SHIFT_EXTRA || {bus.zero, bus.result} !== {1'b0, 32'h1}) begin
            failures++;
            $display("FAIL srl_31: got lat=%0d z=%b res=%h required lat=%0d z=0 res=00000001",
                     lat, bus.zero, bus.result, 1 + 31 * SHIFT_EXTRA);
        end
        take();
        send(ALU_SLL, 32'h0000_0001, 32'd36, ok);
        wait_out(lat);
        checks++;
        if (bus.result !== 32'h0000_0010) begin
            failures++;
            $display("FAIL sll_low_bits: got res=%h required res=00000010", bus.result);
        end
        take();
        send(alu_control_t'(4'hF), 32'd5, 32'd5, ok);
        wait_out(lat);
        checks++;
        if ({bus.overflow, bus.zero, bus.equal, bus.result} !== {3'b011, 32'h0}) begin
            failures++;
            $display("FAIL illegal_op: got ovf=%b z=%b eq=%b res=%h required ovf=0 z=1 eq=1 res=0",
                     bus.overflow, bus.zero, bus.equal, bus.result);
        end
        take();
    endtask

    task automatic test_backpressure();
        bit ok;
        int lat;
        int bad;
        send(ALU_ADD, 32'd3, 32'd4, ok);
        wait_out(lat);
        bus.control  = ALU_SUB;
        bus.a        = 32'd10;
        bus.b        = 32'd4;
        bus.in_valid = 1'b1;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (!bus.out_valid || bus.in_ready || bus.result !== 32'd7 || bus.zero || bus.overflow)
                bad++;
            @(posedge clk);
            #1;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL hold_stable: got %0d unstable cycles required 0", bad);
        end
        bus.out_ready = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL b2b_ready: got in_ready=%b required 1", bus.in_ready);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL b2b_exec: got out_valid=%b busy=%b required out_valid=0 busy=1",
                     bus.out_valid, bus.busy);
        end
        wait_out(lat);
        checks++;
        if (lat != 1 || bus.result !== 32'd6) begin
            failures++;
            $display("FAIL b2b_result: got lat=%0d res=%h required lat=1 res=00000006", lat, bus.result);
        end
        take();
    endtask

    // Streams ops through the scoreboard; rnd randomises in_valid/out_ready and operands.
    task automatic run_stream(input int n_ops, input bit rnd, output int cycles);
        int sent;
        int recv;
        bit acc;
        bit ret;
        alu_control_t op;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [W-1:0] got;
        logic [W-1:0] exp;
        sent   = 0;
        recv   = 0;
        cycles = 0;
        exp_q.delete();
        while (recv < n_ops && cycles < 60000) begin
            if (!bus.in_valid && sent < n_ops && (!rnd || $urandom_range(0, 3) != 0)) begin
                if (rnd) begin
                    op = alu_control_t'(4'($urandom_range(0, 11)));
                    a  = $urandom;
                    b  = ($urandom_range(0, 7) == 0) ? a : $urandom;
                end else begin
                    op = sent[0] ? ALU_SUB : ALU_ADD;
                    a  = sent * 32'h1111_1111;
                    b  = 32'h0123_4567 ^ sent;
                end
                bus.control  = op;
                bus.a        = a;
                bus.b        = b;
                bus.in_valid = 1'b1;
            end
            bus.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            acc = bus.in_valid && bus.in_ready;
            ret = bus.out_valid && bus.out_ready;
            if (ret) begin
                got = {bus.overflow, bus.zero, bus.equal, bus.result};
                recv++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL stream_order: got %h required no result (queue empty)", got);
                end else begin
                    exp = exp_q.pop_front();
                    if (got !== exp) begin
                        failures++;
                        $display("FAIL stream_result %0d: got %h required %h", recv, got, exp);
                    end
                end
            end
            if (acc) begin
                exp_q.push_back(model(bus.control, bus.a, bus.b));
                sent++;
            end
            @(posedge clk);
            #1;
            cycles++;
            if (acc) bus.in_valid = 1'b0;
        end
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        checks++;
        if (recv != n_ops) begin
            failures++;
            $display("FAIL stream_timeout: got %0d results required %0d", recv, n_ops);
        end
    endtask

    task automatic test_back_to_back();
        int cycles;
        run_stream(8, 1'b0, cycles);
        checks++;
        if (cycles != 17) begin
            failures++;
            $display("FAIL b2b_throughput: got %0d cycles required 17", cycles);
        end
    endtask

    task automatic test_random();
        int cycles;
        run_stream(1000, 1'b1, cycles);
    endtask

    initial begin
        drive_idle();
        test_reset();
        test_add_overflow();
        test_sub_slt();
        test_shift();
        test_backpressure();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
